// File: rtl/zion_clr_skid_buf_pkg.sv
// Shared types for the register-slice and FIFO blocks.
// The occupancy state is the number of valid beats held.
package zion_clr_skid_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/zion_clr_skid_buf.sv
// Two-entry ready/valid slice: data out one cycle after accept when empty; oRdy/oVld/oDat all registered.
// Backpressure: a second beat parks in the skid register and oRdy drops until downstream pops; iClr flushes both entries.
module zion_clr_skid_buf
    import zion_clr_skid_buf_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat
);

    skid_state_e      state_q;
    logic             vld_q;
    logic             rdy_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             acc;
    logic             pop;

    assign acc  = iVld & rdy_q;
    assign pop  = vld_q & iRdy;
    assign oRdy = rdy_q;
    assign oVld = vld_q;
    assign oDat = main_q;

    // Handshake flags are registered alongside the state so neither depends on iVld/iRdy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else if (iClr) begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_q <= ONE;
                        vld_q   <= 1'b1;
                        rdy_q   <= 1'b1;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        state_q <= TWO;
                        vld_q   <= 1'b1;
                        rdy_q   <= 1'b0;
                    end else if (!acc && pop) begin
                        state_q <= EMPTY;
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_q <= ONE;
                        vld_q   <= 1'b1;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) main_d = iDat;
            end
            ONE: begin
                if (acc && pop) main_d = iDat;
                else if (acc)   skid_d = iDat;
            end
            TWO: begin
                if (pop) main_d = skid_q;
            end
            default: begin
                main_d = main_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= INI_DATA;
            skid_q <= INI_DATA;
        end else if (iClr) begin
            main_q <= INI_DATA;
            skid_q <= INI_DATA;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // A producer must keep iVld up until its beat is taken; a clear releases it.
    property p_vld_hold;
        @(posedge clk) disable iff (!rst) (iVld && !rdy_q && !iClr) |=> iVld;
    endproperty
    a_vld_hold: assert property (p_vld_hold);

endmodule

// File: tb/tb_zion_clr_skid_buf.sv
module tb_zion_clr_skid_buf;

    localparam logic [31:0] INI = 32'h1;

    logic        clk;
    logic        rst;
    logic        iClr;
    logic        iVld;
    logic        oRdy;
    logic [31:0] iDat;
    logic        oVld;
    logic        iRdy;
    logic [31:0] oDat;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: an ordered list of beats held, capacity two; last = value shown while empty.
    logic [31:0] exp_q[$];
    logic [31:0] last_out = INI;

    zion_clr_skid_buf #(.WIDTH(32), .INI_DATA(32'h1)) dut (
        .clk  (clk),
        .rst  (rst),
        .iClr (iClr),
        .iVld (iVld),
        .oRdy (oRdy),
        .iDat (iDat),
        .oVld (oVld),
        .iRdy (iRdy),
        .oDat (oDat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: outputs after edge N and inputs for edge N+1 are both stable here.
    always @(negedge clk) begin
        logic        e_vld;
        logic        e_rdy;
        logic [31:0] e_dat;
        logic [31:0] got;
        if (!rst) begin
            exp_q.delete();
            last_out = INI;
        end
        e_vld = (exp_q.size() > 0);
        e_rdy = (exp_q.size() < 2);
        e_dat = e_vld ? exp_q[0] : last_out;
        check("oVld", {31'b0, oVld}, {31'b0, e_vld});
        check("oRdy", {31'b0, oRdy}, {31'b0, e_rdy});
        check("oDat", oDat, e_dat);
        if (rst) begin
            if (oVld && iRdy) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pop_empty: got beat %h, expected no beat at %0t", oDat, $time);
                end else begin
                    got = exp_q.pop_front();
                    check("pop_order", oDat, got);
                    last_out = got;
                end
            end
            if (iVld && e_rdy && !iClr) exp_q.push_back(iDat);
            if (iClr) begin
                exp_q.delete();
                last_out = INI;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d);
        logic r;
        iVld = 1'b1;
        iDat = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            r = oRdy;
            @(posedge clk);
            #1;
            if (r) begin
                iVld = 1'b0;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: beat %h never accepted, expected acceptance within 100 cycles", d);
        iVld = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        pend;
        logic [31:0] pdat;
        logic        r_s;
        logic        c_s;
        logic        rdy_n;
        logic        probe;

        rst  = 1'b0;
        iClr = 1'b0;
        iVld = 1'b0;
        iRdy = 1'b0;
        iDat = '0;
        #12;
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(10);

        // Streaming at full rate
        iRdy = 1'b1;
        for (int i = 1; i <= 20; i++) send(i);
        idle(4);

        // Backpressure: fill both entries, hold a third beat, then drain
        iRdy = 1'b0;
        send(32'hA);
        send(32'hB);
        iVld = 1'b1;
        iDat = 32'hC;
        idle(3);
        check("bp_full_ordy", {31'b0, oRdy}, 32'h0);
        check("bp_full_odat", oDat, 32'hA);
        iRdy = 1'b1;
        send(32'hC);
        idle(5);

        // Clear while holding two beats with a beat offered
        iRdy = 1'b0;
        send(32'hA);
        send(32'hB);
        iVld = 1'b1;
        iDat = 32'hD;
        iClr = 1'b1;
        idle(1);
        iClr = 1'b0;
        iVld = 1'b0;
        check("clr_ovld", {31'b0, oVld}, 32'h0);
        check("clr_ordy", {31'b0, oRdy}, 32'h1);
        check("clr_odat", oDat, INI);
        iRdy = 1'b1;
        idle(4);

        // Random traffic with occasional clears
        pend = 1'b0;
        pdat = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            r_s = oRdy;
            c_s = iClr;
            @(posedge clk);
            #1;
            if (iVld && (r_s || c_s)) pend = 1'b0;
            if (!pend) begin
                pend = 1'($urandom_range(0, 1));
                pdat = $urandom;
            end
            iVld  = pend;
            iDat  = pdat;
            iClr  = ($urandom_range(0, 99) < 5);
            rdy_n = 1'($urandom_range(0, 1));
            iRdy  = !rdy_n;
            #1;
            probe = oRdy;
            iRdy  = rdy_n;
            #1;
            check("ordy_vs_irdy", {31'b0, oRdy}, {31'b0, probe});
        end
        @(posedge clk);
        #1;
        iVld = 1'b0;
        iClr = 1'b0;
        iRdy = 1'b1;
        idle(4);

        // Asynchronous reset while one beat is held
        iRdy = 1'b0;
        send(32'h55);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ovld", {31'b0, oVld}, 32'h0);
        check("arst_ordy", {31'b0, oRdy}, 32'h1);
        check("arst_odat", oDat, INI);
        @(posedge clk);
        #1;
        rst = 1'b1;
        iRdy = 1'b1;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
